// File: rtl/mc_fifo_pkg.sv
// Shared constants, width helpers and error classification for the multi-channel FIFO.
// Used by multi_chan_sync_fifo, mc_fifo_chan_ctrl and the bench scoreboard.
package mc_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_AF_LEVEL   = 6;
  localparam int DEF_AE_LEVEL   = 1;

  // Pointer width carries one extra wrap bit so full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UNF
  } fifo_err_e;

endpackage

// File: rtl/mc_fifo_chan_ctrl.sv
// Per-channel bookkeeping: wrap-bit pointers, registered level flags and sticky errors.
// All flags are computed from next-state pointers so they line up with the pointer update.
module mc_fifo_chan_ctrl
  import mc_fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_req_i,
  input  logic                     rd_req_i,
  input  logic                     flag_clr_i,
  output logic                     wr_ok_o,
  output logic                     rd_ok_o,
  output logic [ptr_w(DEPTH)-2:0]  waddr_o,
  output logic [ptr_w(DEPTH)-2:0]  raddr_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     afull_o,
  output logic                     aempty_o,
  output logic                     ovf_o,
  output logic                     unf_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_d;
  logic          full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;

  assign wr_ok_o = wr_req_i && !full_q;
  assign rd_ok_o = rd_req_i && !empty_q;

  always_comb begin
    wptr_d  = wptr_q + PW'(wr_ok_o);
    rptr_d  = rptr_q + PW'(rd_ok_o);
    count_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      full_q   <= (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
      empty_q  <= (wptr_d == rptr_d);
      afull_q  <= (count_d >= AF_CNT);
      aempty_q <= (count_d <= AE_CNT);
      // A fresh error in the same cycle outranks the clear.
      if (wr_req_i && full_q)      ovf_q <= 1'b1;
      else if (flag_clr_i)         ovf_q <= 1'b0;
      if (rd_req_i && empty_q)     unf_q <= 1'b1;
      else if (flag_clr_i)         unf_q <= 1'b0;
    end
  end

  assign waddr_o  = wptr_q[AW-1:0];
  assign raddr_o  = rptr_q[AW-1:0];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;
  assign ovf_o    = ovf_q;
  assign unf_o    = unf_q;

endmodule

// File: rtl/multi_chan_sync_fifo.sv
// Multi-channel single-clock FIFO: NUM_CH circular queues share one storage array.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise the read port is registered.
module multi_chan_sync_fifo
  import mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  w_en,
  input  logic [CH_W-1:0]       w_ch,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  input  logic [CH_W-1:0]       r_ch,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     empty,
  output logic [NUM_CH-1:0]     almost_full,
  output logic [NUM_CH-1:0]     almost_empty,
  output logic [NUM_CH-1:0]     overflow,
  output logic [NUM_CH-1:0]     underflow,
  input  logic                  flag_clr
);

  localparam int AW     = ptr_w(DEPTH) - 1;
  localparam int MEM_AW = CH_W + AW;

  logic [NUM_CH-1:0]     w_hit, r_hit, wr_ok, rd_ok;
  logic [AW-1:0]         waddr [NUM_CH];
  logic [AW-1:0]         raddr [NUM_CH];
  logic [AW-1:0]         waddr_sel, raddr_sel;
  logic [DATA_WIDTH-1:0] mem_q [1<<MEM_AW];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_hit[c] = (w_ch == CH_W'(c));
    assign r_hit[c] = (r_ch == CH_W'(c));

    mc_fifo_chan_ctrl #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
    ) u_ctrl (
      .clk_i      (wclk),
      .rst_ni     (wrst_n),
      .wr_req_i   (w_en && w_hit[c]),
      .rd_req_i   (r_en && r_hit[c]),
      .flag_clr_i (flag_clr),
      .wr_ok_o    (wr_ok[c]),
      .rd_ok_o    (rd_ok[c]),
      .waddr_o    (waddr[c]),
      .raddr_o    (raddr[c]),
      .full_o     (full[c]),
      .empty_o    (empty[c]),
      .afull_o    (almost_full[c]),
      .aempty_o   (almost_empty[c]),
      .ovf_o      (overflow[c]),
      .unf_o      (underflow[c])
    );
  end

  always_comb begin
    waddr_sel = '0;
    raddr_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_hit[c]) waddr_sel = waddr[c];
      if (r_hit[c]) raddr_sel = raddr[c];
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge wclk) begin
    if (|wr_ok) mem_q[{w_ch, waddr_sel}] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem_q[{r_ch, raddr_sel}];
  assign rd_valid = |(r_hit & ~empty);
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= |rd_ok;
      if (|rd_ok) data_out_q <= mem_q[{r_ch, raddr_sel}];
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_multi_chan_sync_fifo.sv
// Self-checking bench for multi_chan_sync_fifo (default registered-read build).
// Reference model keeps one queue per channel plus sticky error bits.
module tb_multi_chan_sync_fifo;
  import mc_fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       w_en = 1'b0, r_en = 1'b0, flag_clr = 1'b0;
  logic [1:0] w_ch = '0, r_ch = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       rd_valid;
  logic [3:0] full, empty, almost_full, almost_empty, overflow, underflow;

  logic [7:0] mq [4][$];
  logic [3:0] m_ovf, m_unf;
  logic [7:0] m_dout;
  logic       m_rv;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  multi_chan_sync_fifo dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .w_en         (w_en),
    .w_ch         (w_ch),
    .data_in      (data_in),
    .r_en         (r_en),
    .r_ch         (r_ch),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .flag_clr     (flag_clr)
  );

  task automatic model_reset();
    for (int c = 0; c < 4; c++) mq[c].delete();
    m_ovf  = '0;
    m_unf  = '0;
    m_dout = '0;
    m_rv   = 1'b0;
  endtask

  task automatic model_flags(output logic [3:0] ef, output logic [3:0] ee,
                             output logic [3:0] eaf, output logic [3:0] eae);
    for (int c = 0; c < 4; c++) begin
      ef[c]  = (mq[c].size() == DEPTH);
      ee[c]  = (mq[c].size() == 0);
      eaf[c] = (mq[c].size() >= AF);
      eae[c] = (mq[c].size() <= AE);
    end
  endtask

  // One clock cycle of stimulus; the model is advanced from pre-edge occupancy.
  task automatic tick(input logic we, input logic [1:0] wc, input logic [7:0] din,
                      input logic re, input logic [1:0] rc, input logic clr);
    bit wacc, racc;
    w_en = we; w_ch = wc; data_in = din; r_en = re; r_ch = rc; flag_clr = clr;
    wacc = we && (mq[wc].size() < DEPTH);
    racc = re && (mq[rc].size() != 0);
    if (clr) begin
      m_ovf = '0;
      m_unf = '0;
    end
    if (we && !wacc) m_ovf[wc] = 1'b1;
    if (re && !racc) m_unf[rc] = 1'b1;
    m_rv = racc;
    if (racc) m_dout = mq[rc].pop_front();
    if (wacc) mq[wc].push_back(din);
    @(posedge wclk);
    #1;
    w_en = 1'b0; r_en = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    model_reset();
    @(posedge wclk);
    #1;
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL reset_empty got %h exp %h", empty, 4'hF); end
    checks++; if (full !== 4'h0) begin errors++; $display("FAIL reset_full got %h exp %h", full, 4'h0); end
    checks++; if (almost_empty !== 4'hF) begin errors++; $display("FAIL reset_aempty got %h exp %h", almost_empty, 4'hF); end
    checks++; if ({almost_full, overflow, underflow} !== 12'h0) begin errors++; $display("FAIL reset_af_err got %h exp 0", {almost_full, overflow, underflow}); end
    checks++; if ({rd_valid, data_out} !== 9'h0) begin errors++; $display("FAIL reset_rd got rv=%b d=%h exp 0", rd_valid, data_out); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 2'd2, 8'(8'h10 + i), 1'b0, 2'd0, 1'b0);
      checks++; if (almost_full[2] !== (i >= 5)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full[2], (i >= 5)); end
      checks++; if (full[2] !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full[2], (i == 7)); end
    end
    tick(1'b1, 2'd2, 8'hFF, 1'b0, 2'd0, 1'b0);
    checks++; if (overflow !== 4'b0100) begin errors++; $display("FAIL fill_ovf got %b exp 0100", overflow); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0);
      checks++; if ({rd_valid, data_out} !== {1'b1, 8'(8'h10 + i)}) begin errors++; $display("FAIL drain_data[%0d] got rv=%b d=%h exp d=%h", i, rd_valid, data_out, 8'(8'h10 + i)); end
      checks++; if ((empty & 4'hB) !== 4'hB) begin errors++; $display("FAIL drain_others_empty got %b exp 1x11", empty); end
    end
    tick(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    checks++; if ({rd_valid, data_out, empty, overflow} !== {1'b0, 8'h17, 4'hF, 4'h0}) begin errors++; $display("FAIL drain_idle got rv=%b d=%h e=%h o=%h", rd_valid, data_out, empty, overflow); end
  endtask

  task automatic test_interleave();
    tick(1'b1, 2'd0, 8'hA0, 1'b0, 2'd0, 1'b0);
    tick(1'b1, 2'd3, 8'hB0, 1'b0, 2'd0, 1'b0);
    tick(1'b1, 2'd0, 8'hA1, 1'b0, 2'd0, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ilv_rv_before got %b exp 0", rd_valid); end
    tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0);
    checks++; if ({rd_valid, data_out} !== {1'b1, 8'hB0}) begin errors++; $display("FAIL ilv_rd3 got rv=%b d=%h exp B0", rd_valid, data_out); end
    tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0);
    checks++; if ({rd_valid, data_out} !== {1'b1, 8'hA0}) begin errors++; $display("FAIL ilv_rd0a got rv=%b d=%h exp A0", rd_valid, data_out); end
    tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0);
    checks++; if ({rd_valid, data_out} !== {1'b1, 8'hA1}) begin errors++; $display("FAIL ilv_rd0b got rv=%b d=%h exp A1", rd_valid, data_out); end
    tick(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    checks++; if ({rd_valid, empty} !== {1'b0, 4'hF}) begin errors++; $display("FAIL ilv_after got rv=%b e=%h exp 0/F", rd_valid, empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) tick(1'b1, 2'd1, 8'(8'h30 + i), 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 2'd1, 8'(8'h33 + i), 1'b1, 2'd1, 1'b0);
      checks++; if ({rd_valid, data_out} !== {1'b1, 8'(8'h30 + i)}) begin errors++; $display("FAIL wrap_data[%0d] got rv=%b d=%h exp %h", i, rd_valid, data_out, 8'(8'h30 + i)); end
      checks++; if ({full[1], empty[1], almost_full[1], almost_empty[1]} !== 4'b0000) begin errors++; $display("FAIL wrap_flags[%0d] got f=%b e=%b af=%b ae=%b", i, full[1], empty[1], almost_full[1], almost_empty[1]); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0);
      checks++; if (data_out !== 8'(8'h44 + i)) begin errors++; $display("FAIL wrap_tail[%0d] got %h exp %h", i, data_out, 8'(8'h44 + i)); end
    end
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty[1]); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 8; i++) tick(1'b1, 2'd1, 8'(8'h50 + i), 1'b0, 2'd0, 1'b0);
    tick(1'b1, 2'd1, 8'hEE, 1'b1, 2'd1, 1'b0);
    checks++; if ({rd_valid, data_out} !== {1'b1, 8'h50}) begin errors++; $display("FAIL bnd_full_rd got rv=%b d=%h exp 50", rd_valid, data_out); end
    checks++; if ({full[1], overflow[1]} !== 2'b01) begin errors++; $display("FAIL bnd_full_ovf got f=%b o=%b exp 0/1", full[1], overflow[1]); end
    tick(1'b1, 2'd0, 8'h66, 1'b1, 2'd0, 1'b0);
    checks++; if ({underflow[0], empty[0], rd_valid} !== 3'b100) begin errors++; $display("FAIL bnd_empty got u=%b e=%b rv=%b exp 1/0/0", underflow[0], empty[0], rd_valid); end
    tick(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    checks++; if ({overflow, underflow} !== 8'h00) begin errors++; $display("FAIL bnd_clr got o=%b u=%b exp 0", overflow, underflow); end
    tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1);
    checks++; if (underflow !== 4'b0100) begin errors++; $display("FAIL bnd_clr_prio got %b exp 0100", underflow); end
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0);
      checks++; if (data_out !== 8'(8'h51 + i)) begin errors++; $display("FAIL bnd_drain[%0d] got %h exp %h", i, data_out, 8'(8'h51 + i)); end
    end
    tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0);
    checks++; if ({rd_valid, data_out} !== {1'b1, 8'h66}) begin errors++; $display("FAIL bnd_ch0 got rv=%b d=%h exp 66", rd_valid, data_out); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, 2'd2, 8'(8'h70 + i), 1'b0, 2'd0, 1'b0);
    w_en = 1'b1; w_ch = 2'd2; data_in = 8'h75;
    #2;
    wrst_n = 1'b0;
    #1;
    model_reset();
    checks++; if ({empty, almost_empty, full, almost_full} !== 16'hFF00) begin errors++; $display("FAIL rstmid_flags got e=%h ae=%h f=%h af=%h", empty, almost_empty, full, almost_full); end
    checks++; if ({rd_valid, data_out, overflow, underflow} !== 17'h0) begin errors++; $display("FAIL rstmid_out got rv=%b d=%h o=%h u=%h", rd_valid, data_out, overflow, underflow); end
    w_en = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    tick(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0);
    checks++; if ({underflow, rd_valid, empty[2]} !== 6'b0100_01) begin errors++; $display("FAIL rstmid_unf got u=%b rv=%b e2=%b exp 0100/0/1", underflow, rd_valid, empty[2]); end
  endtask

  task automatic test_random();
    logic [3:0] ef, ee, eaf, eae;
    for (int i = 0; i < 400; i++) begin
      logic we, re, clr;
      logic [1:0] wc, rc;
      logic [7:0] d;
      we  = ($urandom_range(0, 99) < ((i < 200) ? 75 : 35));
      re  = ($urandom_range(0, 99) < ((i < 200) ? 35 : 75));
      wc  = 2'($urandom_range(0, 3));
      rc  = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      tick(we, wc, d, re, rc, clr);
      model_flags(ef, ee, eaf, eae);
      checks++; if ({full, empty, almost_full, almost_empty} !== {ef, ee, eaf, eae}) begin errors++; $display("FAIL rnd_flags[%0d] got %h exp %h", i, {full, empty, almost_full, almost_empty}, {ef, ee, eaf, eae}); end
      checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_err[%0d] got %h exp %h", i, {overflow, underflow}, {m_ovf, m_unf}); end
      checks++; if ({rd_valid, data_out} !== {m_rv, m_dout}) begin errors++; $display("FAIL rnd_read[%0d] got rv=%b d=%h exp rv=%b d=%h", i, rd_valid, data_out, m_rv, m_dout); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_interleave();
    test_wrap();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
